mouse_position_tracker: RTL and testbench



---
 rtl/mouse_pkg.sv | 29 ++
 rtl/mouse_position_tracker_if.sv | 8 +
 rtl/mouse_axis_accum.sv | 49 ++++
 rtl/mouse_position_tracker.sv | 198 +++++++++++++++++++
 tb/tb_mouse_position_tracker.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse position tracker: packet FSM
// encoding, byte0 bit positions and default screen bounds.
package mouse_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } state_t;

  // Byte0 field positions
  localparam int BIT_L    = 0;
  localparam int BIT_R    = 1;
  localparam int BIT_M    = 2;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XS   = 4;
  localparam int BIT_YS   = 5;
  localparam int BIT_XO   = 6;
  localparam int BIT_YO   = 7;

  // Default screen bounds
  localparam int X_MAX_DEF = 1023;
  localparam int Y_MAX_DEF = 767;

  // Coordinate and accumulator widths
  localparam int POS_W = 12;
  localparam int ACC_W = 13;

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Byte stream from the PS/2 receiver into the position tracker.
interface mouse_position_tracker_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/mouse_axis_accum.sv
// One cursor axis: adds a signed 9-bit PS/2 delta to the current position
// in 13-bit signed arithmetic and clamps the result to 0..MAX.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int MAX  = X_MAX_DEF,
  parameter int INIT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [8:0]       delta,
  input  logic                    ovf,
  input  logic                    inv,
  input  logic                    apply,
  output logic        [POS_W-1:0] pos
);

  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX);

  // Saturate a signed sum into the legal coordinate range.
  function automatic logic [POS_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (v > MAX_S)
      return POS_W'(MAX);
    else
      return v[POS_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] pos_ext;
  logic signed [ACC_W-1:0] sum;

  // Sign-extend the delta (zero on overflow) and add or subtract it.
  always_comb begin
    d_ext   = ovf ? '0 : {{(ACC_W-9){delta[8]}}, delta};
    pos_ext = {1'b0, pos};
    sum     = inv ? (pos_ext - d_ext) : (pos_ext + d_ext);
  end

  // Stage p1: position register takes the clamped sum on apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos <= POS_W'(INIT);
    else if (apply)
      pos <= clamp(sum);
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// PS/2 mouse position tracker: assembles 3-byte movement packets, accumulates
// clamped absolute cursor coordinates and button states.
// Optional build macro MOUSE_VSYNC_LATCH_EN: publish outputs only on the
// rising edge of vsync so the drawn cursor never tears mid-frame.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF,
  parameter int X_INIT  = 512,
  parameter int Y_INIT  = 384,
  parameter int TIMEOUT = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mouse_position_tracker_if.slave      rx,
  input  logic                         vsync,
  output logic [POS_W-1:0]             xpos,
  output logic [POS_W-1:0]             ypos,
  output logic                         left,
  output logic                         right,
  output logic                         middle,
  output logic                         pkt_done,
  output logic                         pkt_err
);

  localparam int              CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t             state;
  logic [CNT_W-1:0]   to_cnt;
  logic               timeout_hit;
  logic               take_b0;
  logic               take_b1;
  logic               take_b2;
  logic               drop_b0;

  logic [2:0]         btn_p0;
  logic               sx_p0;
  logic               sy_p0;
  logic               ox_p0;
  logic               oy_p0;
  logic [7:0]         dx_p0;
  logic [7:0]         dy_p0;
  logic               vld_p0;

  logic [2:0]         btn_p1;
  logic [POS_W-1:0]   x_p1;
  logic [POS_W-1:0]   y_p1;

  // Byte decode; a timeout in the same cycle as a byte forces byte0 handling.
  always_comb begin
    timeout_hit = (state != B0) && (to_cnt == TO_CNT);
    take_b0     = 1'b0;
    take_b1     = 1'b0;
    take_b2     = 1'b0;
    drop_b0     = 1'b0;
    if (rx.rx_valid) begin
      if (timeout_hit || state == B0) begin
        if (rx.rx_data[BIT_SYNC])
          take_b0 = 1'b1;
        else
          drop_b0 = 1'b1;
      end else if (state == B1) begin
        take_b1 = 1'b1;
      end else if (state == B2) begin
        take_b2 = 1'b1;
      end
    end
  end

  // Packet FSM, inter-byte timeout counter and error/apply strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= B0;
      to_cnt  <= '0;
      vld_p0  <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      vld_p0  <= take_b2;
      pkt_err <= timeout_hit | drop_b0;
      if (rx.rx_valid || timeout_hit)
        to_cnt <= '0;
      else if (state != B0)
        to_cnt <= to_cnt + CNT_W'(1);
      if (take_b0)
        state <= B1;
      else if (take_b1)
        state <= B2;
      else if (take_b2 || timeout_hit)
        state <= B0;
    end
  end

  // Stage p0: capture packet fields as bytes arrive.
  always_ff @(posedge clk) begin
    if (take_b0) begin
      btn_p0 <= {rx.rx_data[BIT_M], rx.rx_data[BIT_R], rx.rx_data[BIT_L]};
      sx_p0  <= rx.rx_data[BIT_XS];
      sy_p0  <= rx.rx_data[BIT_YS];
      ox_p0  <= rx.rx_data[BIT_XO];
      oy_p0  <= rx.rx_data[BIT_YO];
    end
    if (take_b1)
      dx_p0 <= rx.rx_data;
    if (take_b2)
      dy_p0 <= rx.rx_data;
  end

  // Stage p1: accumulate X (PS/2 +x is right).
  mouse_axis_accum #(
    .MAX  (X_MAX),
    .INIT (X_INIT)
  ) u_accum_x (
    .clk   (clk),
    .rst_n (rst_n),
    .delta ({sx_p0, dx_p0}),
    .ovf   (ox_p0),
    .inv   (1'b0),
    .apply (vld_p0),
    .pos   (x_p1)
  );

  // Stage p1: accumulate Y inverted (PS/2 +y is up, screen +y is down).
  mouse_axis_accum #(
    .MAX  (Y_MAX),
    .INIT (Y_INIT)
  ) u_accum_y (
    .clk   (clk),
    .rst_n (rst_n),
    .delta ({sy_p0, dy_p0}),
    .ovf   (oy_p0),
    .inv   (1'b1),
    .apply (vld_p0),
    .pos   (y_p1)
  );

  // Stage p1: button state and packet-applied pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p1   <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= vld_p0;
      if (vld_p0)
        btn_p1 <= btn_p0;
    end
  end

`ifdef MOUSE_VSYNC_LATCH_EN
  logic vsync_q;
  logic frame_edge;

  assign frame_edge = vsync & ~vsync_q;

  // Stage p2: publish internal state only at the start of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      xpos    <= POS_W'(X_INIT);
      ypos    <= POS_W'(Y_INIT);
      left    <= 1'b0;
      right   <= 1'b0;
      middle  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (frame_edge) begin
        xpos   <= x_p1;
        ypos   <= y_p1;
        left   <= btn_p1[0];
        right  <= btn_p1[1];
        middle <= btn_p1[2];
      end
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync;

  // Stage p2: outputs follow internal state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos   <= POS_W'(X_INIT);
      ypos   <= POS_W'(Y_INIT);
      left   <= 1'b0;
      right  <= 1'b0;
      middle <= 1'b0;
    end else begin
      xpos   <= x_p1;
      ypos   <= y_p1;
      left   <= btn_p1[0];
      right  <= btn_p1[1];
      middle <= btn_p1[2];
    end
  end
`endif

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed testbench for mouse_position_tracker (default build; the vsync
// latching scenario is compiled when MOUSE_VSYNC_LATCH_EN is defined).
module tb_mouse_position_tracker;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic        middle;
  logic        pkt_done;
  logic        pkt_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  mouse_position_tracker_if rx_if ();

  mouse_position_tracker #(
    .X_MAX   (1023),
    .Y_MAX   (767),
    .X_INIT  (512),
    .Y_INIT  (384),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx_if),
    .vsync    (vsync),
    .xpos     (xpos),
    .ypos     (ypos),
    .left     (left),
    .right    (right),
    .middle   (middle),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data = 8'h00;
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_data = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data = 8'h00;
    @(negedge clk);
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL reset_x: got %0d want 512", xpos); end
    tests++; if (ypos !== 12'd384) begin fails++; $display("FAIL reset_y: got %0d want 384", ypos); end
    tests++; if ({left, right, middle} !== 3'b000) begin fails++; $display("FAIL reset_btn: got %b want 000", {left, right, middle}); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if ({pkt_done, pkt_err} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00 cycle %0d", {pkt_done, pkt_err}, i); end
    end
    tests++; if (xpos !== 12'd512 || ypos !== 12'd384) begin fails++; $display("FAIL reset_idle_pos: got %0d,%0d want 512,384", xpos, ypos); end
  endtask

  task automatic test_basic();
    int snap;
    apply_reset();
    snap = done_cnt;
    send_pkt(8'h09, 8'h05, 8'h03);
    tests++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL basic_done_early: got %b want 0", pkt_done); end
    @(negedge clk);
    tests++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL basic_done: got %b want 1", pkt_done); end
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL basic_x_latency: got %0d want 512", xpos); end
    @(negedge clk);
    tests++; if (xpos !== 12'd517) begin fails++; $display("FAIL basic_x: got %0d want 517", xpos); end
    tests++; if (ypos !== 12'd381) begin fails++; $display("FAIL basic_y: got %0d want 381", ypos); end
    tests++; if ({left, right, middle} !== 3'b100) begin fails++; $display("FAIL basic_btn: got %b want 100", {left, right, middle}); end
    repeat (2) @(negedge clk);
    tests++; if (done_cnt - snap !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - snap); end
  endtask

  task automatic test_negative();
    apply_reset();
    send_pkt(8'h38, 8'hF6, 8'hF6);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd502) begin fails++; $display("FAIL neg_x: got %0d want 502", xpos); end
    tests++; if (ypos !== 12'd394) begin fails++; $display("FAIL neg_y: got %0d want 394", ypos); end
    for (int i = 0; i < 5; i++) begin
      send_pkt(8'h08, 8'h7F, 8'h00);
      repeat (2) @(negedge clk);
      if (i == 3) begin
        tests++; if (xpos !== 12'd1010) begin fails++; $display("FAIL sat_x_pre: got %0d want 1010", xpos); end
      end
    end
    tests++; if (xpos !== 12'd1023) begin fails++; $display("FAIL sat_x: got %0d want 1023", xpos); end
    tests++; if (ypos !== 12'd394) begin fails++; $display("FAIL sat_y_hold: got %0d want 394", ypos); end
  endtask

  task automatic test_clamp();
    apply_reset();
    for (int i = 0; i < 4; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd1020) begin fails++; $display("FAIL clamp_x_1020: got %0d want 1020", xpos); end
    send_pkt(8'h08, 8'h0A, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd1023) begin fails++; $display("FAIL clamp_x_hi: got %0d want 1023", xpos); end
    for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h00, 8'h7F);
    send_pkt(8'h08, 8'h00, 8'h01);
    repeat (2) @(negedge clk);
    tests++; if (ypos !== 12'd2) begin fails++; $display("FAIL clamp_y_2: got %0d want 2", ypos); end
    send_pkt(8'h08, 8'h00, 8'h05);
    repeat (2) @(negedge clk);
    tests++; if (ypos !== 12'd0) begin fails++; $display("FAIL clamp_y_lo: got %0d want 0", ypos); end
    apply_reset();
    for (int i = 0; i < 4; i++) send_pkt(8'h18, 8'h80, 8'h00);
    send_pkt(8'h18, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd0) begin fails++; $display("FAIL clamp_x_lo: got %0d want 0", xpos); end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_pkt(8'h4E, 8'h50, 8'h05);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL ovf_x: got %0d want 512", xpos); end
    tests++; if (ypos !== 12'd379) begin fails++; $display("FAIL ovf_x_y: got %0d want 379", ypos); end
    tests++; if ({left, right, middle} !== 3'b011) begin fails++; $display("FAIL ovf_btn: got %b want 011", {left, right, middle}); end
    send_pkt(8'h88, 8'h00, 8'h50);
    repeat (2) @(negedge clk);
    tests++; if (ypos !== 12'd379) begin fails++; $display("FAIL ovf_y: got %0d want 379", ypos); end
    tests++; if ({left, right, middle} !== 3'b000) begin fails++; $display("FAIL ovf_btn_clear: got %b want 000", {left, right, middle}); end
  endtask

  task automatic test_resync();
    apply_reset();
    send_byte(8'h00);
    tests++; if (pkt_err !== 1'b1) begin fails++; $display("FAIL resync_err: got %b want 1", pkt_err); end
    @(negedge clk);
    tests++; if (pkt_err !== 1'b0) begin fails++; $display("FAIL resync_err_pulse: got %b want 0", pkt_err); end
    send_pkt(8'h08, 8'h01, 8'h01);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd513) begin fails++; $display("FAIL resync_x: got %0d want 513", xpos); end
    tests++; if (ypos !== 12'd383) begin fails++; $display("FAIL resync_y: got %0d want 383", ypos); end
  endtask

  task automatic test_timeout();
    int seen;
    apply_reset();
    send_byte(8'h08);
    send_byte(8'h05);
    seen = -1;
    for (int i = 1; i <= TO + 10; i++) begin
      @(negedge clk);
      if (pkt_err === 1'b1) begin
        seen = i;
        break;
      end
    end
    tests++; if (seen !== TO + 1) begin fails++; $display("FAIL timeout_cycle: got %0d want %0d", seen, TO + 1); end
    send_pkt(8'h08, 8'h02, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd514) begin fails++; $display("FAIL timeout_x: got %0d want 514", xpos); end
    tests++; if (ypos !== 12'd384) begin fails++; $display("FAIL timeout_y: got %0d want 384", ypos); end
  endtask

  task automatic test_timeout_collision();
    apply_reset();
    send_byte(8'h08);
    repeat (TO) @(negedge clk);
    tests++; if (pkt_err !== 1'b0) begin fails++; $display("FAIL coll_err_early: got %b want 0", pkt_err); end
    send_byte(8'h18);
    tests++; if (pkt_err !== 1'b1) begin fails++; $display("FAIL coll_err: got %b want 1", pkt_err); end
    send_byte(8'hFF);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd511) begin fails++; $display("FAIL coll_x: got %0d want 511", xpos); end
    send_byte(8'h08);
    repeat (TO) @(negedge clk);
    send_byte(8'h01);
    tests++; if (pkt_err !== 1'b1) begin fails++; $display("FAIL coll_drop_err: got %b want 1", pkt_err); end
    send_pkt(8'h08, 8'h01, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL coll_drop_x: got %0d want 512", xpos); end
  endtask

  task automatic test_back_to_back();
    int snap;
    apply_reset();
    snap = done_cnt;
    send_pkt(8'h08, 8'h03, 8'h00);
    send_pkt(8'h0A, 8'h04, 8'h02);
    repeat (3) @(negedge clk);
    tests++; if (done_cnt - snap !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - snap); end
    tests++; if (xpos !== 12'd519) begin fails++; $display("FAIL b2b_x: got %0d want 519", xpos); end
    tests++; if (ypos !== 12'd382) begin fails++; $display("FAIL b2b_y: got %0d want 382", ypos); end
    tests++; if ({left, right, middle} !== 3'b010) begin fails++; $display("FAIL b2b_btn: got %b want 010", {left, right, middle}); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_pkt(8'h08, 8'h05, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd517) begin fails++; $display("FAIL rmid_pre_x: got %0d want 517", xpos); end
    send_byte(8'h08);
    send_byte(8'h05);
    rst_n = 1'b0;
    #1;
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL rmid_async_x: got %0d want 512", xpos); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(8'h08, 8'h02, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd514) begin fails++; $display("FAIL rmid_x: got %0d want 514", xpos); end
  endtask

`ifdef MOUSE_VSYNC_LATCH_EN
  task automatic test_vsync();
    apply_reset();
    send_pkt(8'h09, 8'h05, 8'h00);
    repeat (3) @(negedge clk);
    tests++; if (xpos !== 12'd512) begin fails++; $display("FAIL vs_hold_x: got %0d want 512", xpos); end
    tests++; if (left !== 1'b0) begin fails++; $display("FAIL vs_hold_btn: got %b want 0", left); end
    vsync = 1'b1;
    @(negedge clk);
    tests++; if (xpos !== 12'd517) begin fails++; $display("FAIL vs_edge_x: got %0d want 517", xpos); end
    tests++; if (left !== 1'b1) begin fails++; $display("FAIL vs_edge_btn: got %b want 1", left); end
    vsync = 1'b0;
    @(negedge clk);
    send_pkt(8'h08, 8'h05, 8'h00);
    vsync = 1'b1;
    @(negedge clk);
    tests++; if (pkt_done !== 1'b1) begin fails++; $display("FAIL vs_same_done: got %b want 1", pkt_done); end
    tests++; if (xpos !== 12'd517) begin fails++; $display("FAIL vs_same_x: got %0d want 517", xpos); end
    repeat (3) @(negedge clk);
    tests++; if (xpos !== 12'd517) begin fails++; $display("FAIL vs_high_x: got %0d want 517", xpos); end
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    tests++; if (xpos !== 12'd522) begin fails++; $display("FAIL vs_next_x: got %0d want 522", xpos); end
    vsync = 1'b0;
  endtask
`else
  task automatic test_vsync();
    apply_reset();
    vsync = 1'b1;
    send_pkt(8'h08, 8'h03, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (xpos !== 12'd515) begin fails++; $display("FAIL vs_ignored_x: got %0d want 515", xpos); end
    vsync = 1'b0;
  endtask
`endif

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_clamp();
    test_overflow();
    test_resync();
    test_timeout();
    test_timeout_collision();
    test_back_to_back();
    test_reset_mid();
    test_vsync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
